mips32_mem_responder: RTL

- Memory-side responder for the MIPS32 pipeline's data/instruction memory port.
- The pipeline's MEM stage, or a program loader, issues word reads and writes over a valid/ready request channel. This block services them from a DEPTH x 32 word array and returns in-order responses over a valid/ready response channel.
- It replaces direct array indexing, so the core can tolerate back-pressure and flag illegal addresses.

---
 rtl/mips32_pkg.sv | 44 ++++
 rtl/mips32_mem_responder_if.sv | 31 +++
 rtl/mips32_rsp_fifo.sv | 50 +++++
 rtl/mips32_mem_responder.sv | 65 ++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// mips32_pkg: shared core constants, memory geometry and the
// memory response record carried by the response queue.
package mips32_pkg;

  localparam logic [5:0] ADD  = 6'b000000;
  localparam logic [5:0] SUB  = 6'b000001;
  localparam logic [5:0] AND  = 6'b000010;
  localparam logic [5:0] OR   = 6'b000011;
  localparam logic [5:0] SLT  = 6'b000100;
  localparam logic [5:0] MUL  = 6'b000101;
  localparam logic [5:0] HLT  = 6'b111111;
  localparam logic [5:0] LW   = 6'b001000;
  localparam logic [5:0] SW   = 6'b001001;
  localparam logic [5:0] ADDI = 6'b001010;
  localparam logic [5:0] SUBI = 6'b001011;
  localparam logic [5:0] SLTI = 6'b001100;
  localparam logic [5:0] BNEQZ = 6'b001101;
  localparam logic [5:0] BEQZ = 6'b001110;

  localparam int MEM_DEPTH = 1024;
  localparam int MEM_AW    = 10;

  typedef struct packed {
    logic        we;
    logic        err;
    logic [31:0] rdata;
  } mem_rsp_t;

  localparam int RSP_W = $bits(mem_rsp_t);

  // Writes and errors never return data.
  function automatic mem_rsp_t mk_rsp(
    input logic        we,
    input logic        err,
    input logic [31:0] rd
  );
    mem_rsp_t r;
    r.we    = we;
    r.err   = err;
    r.rdata = (we || err) ? 32'h0 : rd;
    return r;
  endfunction

endpackage

// File: rtl/mips32_mem_responder_if.sv
// mips32_mem_responder_if: request/response valid-ready bundle
// between a requester (master) and the memory responder (slave).
interface mips32_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_we;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, rsp_we, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, rsp_we, busy
  );

endinterface

// File: rtl/mips32_rsp_fifo.sv
// mips32_rsp_fifo: DEPTH x W circular queue, push/pop same edge ok.
// Ports: clk1, reset, push/din, pop/dout, full, empty, count.
module mips32_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 34
) (
  input  logic                   clk1,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only count decides validity.
  always_ff @(posedge clk1) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mips32_mem_responder.sv
// mips32_mem_responder: DEPTH x 32 word memory behind a valid/ready
// request channel; in-order responses via a small queue. Ports: clk1, reset, bus.
module mips32_mem_responder
  import mips32_pkg::*;
#(
  parameter int DEPTH    = MEM_DEPTH,
  parameter int AW       = MEM_AW,
  parameter int RQ_DEPTH = 2
) (
  input  logic clk1,
  input  logic reset,
  mips32_mem_responder_if.slave bus
);

  localparam int CW = $clog2(RQ_DEPTH) + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          in_range;
  logic          accept;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  mem_rsp_t      push_rsp;
  mem_rsp_t      head;

  assign idx      = bus.req_addr[AW-1:0];
  // Full 32-bit compare so high addresses never alias low words.
  assign in_range = (bus.req_addr < 32'(DEPTH));

  assign pop           = bus.rsp_valid && bus.rsp_ready;
  assign bus.req_ready = !reset && (!full || pop);
  assign accept        = bus.req_valid && bus.req_ready;

  // Read sees the array before any write on the same edge.
  assign push_rsp = mk_rsp(bus.req_we, !in_range, mem[idx]);

  // Array is deliberately not reset so the image survives restart.
  always_ff @(posedge clk1) begin
    if (accept && bus.req_we && in_range) mem[idx] <= bus.req_wdata;
  end

  mips32_rsp_fifo #(
    .DEPTH (RQ_DEPTH),
    .W     (RSP_W)
  ) u_fifo (
    .clk1  (clk1),
    .reset (reset),
    .push  (accept),
    .din   (push_rsp),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.rsp_valid = !empty;
  assign bus.rsp_rdata = bus.rsp_valid ? head.rdata : 32'h0;
  assign bus.rsp_err   = bus.rsp_valid && head.err;
  assign bus.rsp_we    = bus.rsp_valid && head.we;
  assign bus.busy      = bus.rsp_valid || (count != '0);

endmodule
